instr_fetch: RTL and testbench

Instruction fetch stage that feeds the multi-cycle control unit's decode step. It owns the program counter for sequential fetch, issues reads to the shared synchronous memory (`MemReadWrite`), and waits a fixed read latency. Fetched words go into a small instruction buffer that decode drains with a valid/ready handshake. Jump and branch targets arrive as redirects that flush the buffer. A halt request releases the memory port so the sink/inference path can use it.

---
 rtl/instr_fetch.sv | 161 ++++++++++++++++
 tb/tb_instr_fetch.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// instr_fetch: program-counter owner and memory-read sequencer for the decode stage.
// Reads go to a shared synchronous memory with a fixed latency. Fetched words are
// queued in a small FIFO that decode drains with instr_valid/instr_ready.
// Build option FETCH_PREFETCH_EN: 2-entry buffer, so the next read overlaps decode.
// Without it the buffer has one entry and fetch/decode alternate strictly.
module instr_fetch #(
   parameter int unsigned MEM_LATENCY = 3,
   parameter logic [31:0] RESET_PC    = 32'd0,
   parameter int unsigned ADDR_W      = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   output logic              mem_en,
   output logic              mem_ren,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [31:0]       mem_dout,
   output logic              instr_valid,
   output logic [31:0]       instr,
   output logic [31:0]       instr_pc,
   input  logic              instr_ready,
   input  logic              redirect,
   input  logic [31:0]       redirect_pc,
   input  logic              halt,
   output logic              busy
);

`ifdef FETCH_PREFETCH_EN
   localparam int unsigned DEPTH = 2;
`else
   localparam int unsigned DEPTH = 1;
`endif

   localparam logic [3:0] LAT = 4'(MEM_LATENCY);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_WAIT   = 2'd1;
   localparam logic [1:0] S_STALL  = 2'd2;
   localparam logic [1:0] S_HALTED = 2'd3;

   logic [1:0]  state;
   logic [3:0]  cnt;
   logic [31:0] fetch_pc;
   logic [1:0]  count;
   logic [31:0] buf_data [DEPTH];
   logic [31:0] buf_pc   [DEPTH];

   logic        capture;
   logic        flush;
   logic        do_pop;
   logic        do_push;
   logic [1:0]  wr_idx;
   logic [1:0]  count_after;
   logic [31:0] next_pc;

   assign instr_valid = (count != 2'd0);
   assign instr       = buf_data[0];
   assign instr_pc    = buf_pc[0];
   assign mem_ren     = mem_en;
   assign busy        = (state == S_WAIT) || (state == S_STALL);

   // Per-cycle control: halt/redirect flush the buffer and suppress capture and pop.
   always_comb begin
      capture     = (state == S_WAIT) && (cnt == 4'd1);
      flush       = (halt || redirect) && (state != S_HALTED);
      do_pop      = instr_valid && instr_ready && !flush;
      do_push     = capture && !flush;
      wr_idx      = count - {1'b0, do_pop};
      count_after = wr_idx + {1'b0, do_push};
      next_pc     = fetch_pc + 32'd1;
   end

   // Instruction FIFO as a shift queue: head at index 0, push lands after the survivors.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            buf_data[i] <= '0;
            buf_pc[i]   <= '0;
         end
      end else if (flush) begin
         count <= '0;
      end else begin
         count <= count_after;
         if (do_pop) begin
            for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
               buf_data[i] <= buf_data[i+1];
               buf_pc[i]   <= buf_pc[i+1];
            end
         end
         if (do_push) begin
            assert (wr_idx < 2'(DEPTH));
            for (int unsigned i = 0; i < DEPTH; i++) begin
               if (wr_idx == 2'(i)) begin
                  buf_data[i] <= mem_dout;
                  buf_pc[i]   <= fetch_pc;
               end
            end
         end
      end
   end

   // Fetch FSM: PC sequencing, read issue and latency countdown; halt beats redirect beats capture/pop.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= S_IDLE;
         cnt      <= '0;
         fetch_pc <= RESET_PC;
         mem_en   <= 1'b0;
         mem_addr <= '0;
      end else if (halt && (state != S_HALTED)) begin
         state  <= S_HALTED;
         cnt    <= '0;
         mem_en <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (redirect) begin
                  fetch_pc <= redirect_pc;
               end else if (start) begin
                  mem_en   <= 1'b1;
                  mem_addr <= fetch_pc[ADDR_W-1:0];
                  cnt      <= LAT;
                  state    <= S_WAIT;
               end
            end
            S_WAIT, S_STALL: begin
               if (redirect) begin
                  fetch_pc <= redirect_pc;
                  mem_en   <= 1'b1;
                  mem_addr <= redirect_pc[ADDR_W-1:0];
                  cnt      <= LAT;
                  state    <= S_WAIT;
               end else if (state == S_WAIT) begin
                  if (capture) begin
                     fetch_pc <= next_pc;
                     if (count_after < 2'(DEPTH)) begin
                        mem_addr <= next_pc[ADDR_W-1:0];
                        cnt      <= LAT;
                     end else begin
                        mem_en <= 1'b0;
                        cnt    <= '0;
                        state  <= S_STALL;
                     end
                  end else begin
                     cnt <= cnt - 4'd1;
                  end
               end else if (do_pop) begin
                  mem_en   <= 1'b1;
                  mem_addr <= fetch_pc[ADDR_W-1:0];
                  cnt      <= LAT;
                  state    <= S_WAIT;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with MEM_LATENCY=3; expectations cover both buffer depths.
module tb_instr_fetch;

`ifdef FETCH_PREFETCH_EN
   localparam int unsigned STEP = 3;
   localparam logic        PF   = 1'b1;
`else
   localparam int unsigned STEP = 4;
   localparam logic        PF   = 1'b0;
`endif

   logic        clk;
   logic        reset_n;
   logic        start;
   logic        mem_en;
   logic        mem_ren;
   logic [15:0] mem_addr;
   logic [31:0] mem_dout;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_ready;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        halt;
   logic        busy;

   logic [31:0] mem [256];

   int checks = 0;
   int passes = 0;
   int fails  = 0;

   instr_fetch #(.MEM_LATENCY(3), .RESET_PC(32'd0), .ADDR_W(16)) dut (
      .clk(clk), .reset_n(reset_n), .start(start),
      .mem_en(mem_en), .mem_ren(mem_ren), .mem_addr(mem_addr), .mem_dout(mem_dout),
      .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready),
      .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt), .busy(busy)
   );

   assign mem_dout = mem[mem_addr[7:0]];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      start = 1'b0; redirect = 1'b0; halt = 1'b0; instr_ready = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
   endtask

   task automatic go();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'hD000_0000 | 32'(i);
      mem[0] = 32'h0000_000A;
      mem[1] = 32'h0000_000B;
      mem[2] = 32'h0000_000C;
      reset_n = 1'b0; start = 1'b0; instr_ready = 1'b0;
      redirect = 1'b0; redirect_pc = '0; halt = 1'b0;
      tick();

      // reset values
      check("rst_mem_en", 32'(mem_en), 32'd0);
      check("rst_mem_ren", 32'(mem_ren), 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      check("rst_valid", 32'(instr_valid), 32'd0);
      check("rst_instr", instr, 32'd0);
      check("rst_instr_pc", instr_pc, 32'd0);
      check("rst_busy", 32'(busy), 32'd0);

      // sequential fetch with decode always ready
      do_reset();
      instr_ready = 1'b1;
      go();
      check("t1_issue_en", 32'(mem_en), 32'd1);
      check("t1_issue_ren", 32'(mem_ren), 32'd1);
      check("t1_issue_addr", 32'(mem_addr), 32'd0);
      check("t1_busy", 32'(busy), 32'd1);
      tick(); tick();
      check("t1_e2_valid", 32'(instr_valid), 32'd0);
      tick();
      check("t1_e3_valid", 32'(instr_valid), 32'd1);
      check("t1_e3_instr", instr, 32'h0000_000A);
      check("t1_e3_pc", instr_pc, 32'd0);
      check("t1_e3_mem_en", 32'(mem_en), 32'(PF));
      tick();
      check("t1_e4_valid", 32'(instr_valid), 32'd0);
      check("t1_e4_addr", 32'(mem_addr), 32'd1);
      repeat (STEP - 1) tick();
      check("t1_b_valid", 32'(instr_valid), 32'd1);
      check("t1_b_instr", instr, 32'h0000_000B);
      check("t1_b_pc", instr_pc, 32'd1);
      repeat (STEP) tick();
      check("t1_c_instr", instr, 32'h0000_000C);
      check("t1_c_pc", instr_pc, 32'd2);

      // back-pressure: decode not ready
      do_reset();
      go();
`ifdef FETCH_PREFETCH_EN
      repeat (6) tick();
      check("t2_full_valid", 32'(instr_valid), 32'd1);
      check("t2_full_instr", instr, 32'h0000_000A);
      check("t2_full_pc", instr_pc, 32'd0);
      check("t2_stall_en", 32'(mem_en), 32'd0);
      check("t2_stall_addr", 32'(mem_addr), 32'd1);
      check("t2_stall_busy", 32'(busy), 32'd1);
      tick(); tick();
      check("t2_stall_hold", 32'(mem_en), 32'd0);
      instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0;
      check("t2_pop_en", 32'(mem_en), 32'd1);
      check("t2_pop_addr", 32'(mem_addr), 32'd2);
      check("t2_pop_instr", instr, 32'h0000_000B);
      check("t2_pop_pc", instr_pc, 32'd1);
      repeat (3) tick();
      check("t2_refull_en", 32'(mem_en), 32'd0);
      check("t2_refull_instr", instr, 32'h0000_000B);
`else
      repeat (3) tick();
      check("t2_full_valid", 32'(instr_valid), 32'd1);
      check("t2_full_instr", instr, 32'h0000_000A);
      check("t2_stall_en", 32'(mem_en), 32'd0);
      check("t2_stall_busy", 32'(busy), 32'd1);
      tick(); tick();
      check("t2_stall_hold", 32'(mem_en), 32'd0);
      instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0;
      check("t2_pop_en", 32'(mem_en), 32'd1);
      check("t2_pop_addr", 32'(mem_addr), 32'd1);
      check("t2_pop_valid", 32'(instr_valid), 32'd0);
      repeat (3) tick();
      check("t2_b_instr", instr, 32'h0000_000B);
      check("t2_b_pc", instr_pc, 32'd1);
      check("t2_b_en", 32'(mem_en), 32'd0);
`endif

      // redirect one cycle before a capture
      do_reset();
      go();
      repeat (4) tick();
      redirect = 1'b1; redirect_pc = 32'h40;
      tick();
      redirect = 1'b0;
      check("t3_flush_valid", 32'(instr_valid), 32'd0);
      check("t3_redir_en", 32'(mem_en), 32'd1);
      check("t3_redir_addr", 32'(mem_addr), 32'h40);
      tick();
      check("t3_no_stale", 32'(instr_valid), 32'd0);
      tick();
      check("t3_wait_valid", 32'(instr_valid), 32'd0);
      tick();
      check("t3_cap_valid", 32'(instr_valid), 32'd1);
      check("t3_cap_instr", instr, 32'hD000_0040);
      check("t3_cap_pc", instr_pc, 32'h40);

      // redirect and pop together with a full buffer
`ifdef FETCH_PREFETCH_EN
      repeat (3) tick();
`endif
      check("t4_full_en", 32'(mem_en), 32'd0);
      check("t4_full_valid", 32'(instr_valid), 32'd1);
      instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h80;
      tick();
      redirect = 1'b0;
      check("t4_flush_valid", 32'(instr_valid), 32'd0);
      check("t4_redir_addr", 32'(mem_addr), 32'h80);
      check("t4_redir_en", 32'(mem_en), 32'd1);
      tick(); tick();
      check("t4_no_dup", 32'(instr_valid), 32'd0);
      tick();
      check("t4_cap_valid", 32'(instr_valid), 32'd1);
      check("t4_cap_instr", instr, 32'hD000_0080);
      check("t4_cap_pc", instr_pc, 32'h80);
      tick();
      check("t4_popped", 32'(instr_valid), 32'd0);

      // halt while a read is outstanding
      halt = 1'b1;
      tick();
      halt = 1'b0;
      check("t5_halt_en", 32'(mem_en), 32'd0);
      check("t5_halt_ren", 32'(mem_ren), 32'd0);
      check("t5_halt_valid", 32'(instr_valid), 32'd0);
      check("t5_halt_busy", 32'(busy), 32'd0);
      redirect = 1'b1; redirect_pc = 32'h10; start = 1'b1;
      tick();
      redirect = 1'b0; start = 1'b0;
      check("t5_ign_en", 32'(mem_en), 32'd0);
      check("t5_ign_addr", 32'(mem_addr), 32'h81);
      check("t5_ign_busy", 32'(busy), 32'd0);
      repeat (4) tick();
      check("t5_later_valid", 32'(instr_valid), 32'd0);
      check("t5_later_en", 32'(mem_en), 32'd0);

      // asynchronous reset in the middle of a read
      do_reset();
      check("t6_exit_busy", 32'(busy), 32'd0);
      go();
      redirect = 1'b1; redirect_pc = 32'h20;
      tick();
      redirect = 1'b0;
      check("t6_pre_addr", 32'(mem_addr), 32'h20);
      #3;
      reset_n = 1'b0;
      #1;
      check("t6_async_en", 32'(mem_en), 32'd0);
      check("t6_async_addr", 32'(mem_addr), 32'd0);
      check("t6_async_busy", 32'(busy), 32'd0);
      check("t6_async_valid", 32'(instr_valid), 32'd0);
      #2;
      reset_n = 1'b1;
      go();
      check("t6_restart_addr", 32'(mem_addr), 32'd0);
      check("t6_restart_en", 32'(mem_en), 32'd1);
      repeat (3) tick();
      check("t6_restart_instr", instr, 32'h0000_000A);
      check("t6_restart_pc", instr_pc, 32'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
